// File: rtl/button_ctrl.sv
// Multi-button front end: per-channel synchroniser, debouncer and press/release/long-press
// event generator, plus a wrapping up/down LED counter driven by channels 0 and 1.
module button_ctrl #(
    parameter int NUM_BTN           = 2,
    parameter int LED_WIDTH         = 4,
    parameter int DEBOUNCE_CYCLES   = 1000000,
    parameter int LONG_PRESS_CYCLES = 100000000,
    parameter bit BTN_ACTIVE_LOW    = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_BTN-1:0]   btn,
    output logic [NUM_BTN-1:0]   btn_level,
    output logic [NUM_BTN-1:0]   btn_press,
    output logic [NUM_BTN-1:0]   btn_release,
    output logic [NUM_BTN-1:0]   btn_long,
    output logic [LED_WIDTH-1:0] led
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int HW = $clog2(LONG_PRESS_CYCLES);

    localparam logic [DW-1:0]        DB_ZERO   = {DW{1'b0}};
    localparam logic [DW-1:0]        DB_ONE    = DW'(1);
    localparam logic [DW-1:0]        DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0]        HOLD_ZERO = {HW{1'b0}};
    localparam logic [HW-1:0]        HOLD_ONE  = HW'(1);
    localparam logic [HW-1:0]        HOLD_LAST = HW'(LONG_PRESS_CYCLES - 1);
    localparam logic [HW-1:0]        HOLD_FIRE = HW'(LONG_PRESS_CYCLES - 2);
    localparam logic [NUM_BTN-1:0]   RAW_IDLE  = {NUM_BTN{BTN_ACTIVE_LOW}};
    localparam logic [NUM_BTN-1:0]   BTN_ZERO  = {NUM_BTN{1'b0}};
    localparam logic [LED_WIDTH-1:0] LED_ZERO  = {LED_WIDTH{1'b0}};
    localparam logic [LED_WIDTH-1:0] LED_ONE   = LED_WIDTH'(1);

    logic [NUM_BTN-1:0]   sync1_q, sync2_q;
    logic [NUM_BTN-1:0]   pressed_s;
    logic [NUM_BTN-1:0]   stable_q, stable_d;
    logic [DW-1:0]        db_cnt_q [NUM_BTN];
    logic [DW-1:0]        db_cnt_d [NUM_BTN];
    logic [HW-1:0]        hold_q   [NUM_BTN];
    logic [HW-1:0]        hold_d   [NUM_BTN];
    logic [NUM_BTN-1:0]   level_q, level_d;
    logic [NUM_BTN-1:0]   press_q, press_d;
    logic [NUM_BTN-1:0]   release_q, release_d;
    logic [NUM_BTN-1:0]   long_q, long_d;
    logic [LED_WIDTH-1:0] led_q, led_d;
    logic                 dec_s;

    // Synchronisers reset to the idle raw level so a held button is seen as a fresh press.
    assign pressed_s = sync2_q ^ RAW_IDLE;

    generate
        if (NUM_BTN >= 2) begin : g_dec
            assign dec_s = press_q[1];
        end else begin : g_no_dec
            assign dec_s = 1'b0;
        end
    endgenerate

    // Debounce: count consecutive disagreeing samples, flip the stable state on the last one.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < NUM_BTN; i++) begin
            db_cnt_d[i] = db_cnt_q[i];
            if (pressed_s[i] == stable_q[i]) begin
                db_cnt_d[i] = DB_ZERO;
            end else if (db_cnt_q[i] == DB_LAST) begin
                db_cnt_d[i] = DB_ZERO;
                stable_d[i] = ~stable_q[i];
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + DB_ONE;
            end
        end
    end

    // Event stage: level/edge pulses one cycle behind the stable state, saturating hold timer.
    always_comb begin
        level_d   = stable_q;
        press_d   = stable_q & ~level_q;
        release_d = ~stable_q & level_q;
        long_d    = BTN_ZERO;
        for (int i = 0; i < NUM_BTN; i++) begin
            hold_d[i] = hold_q[i];
            if (!level_q[i]) begin
                hold_d[i] = HOLD_ZERO;
            end else if (hold_q[i] == HOLD_LAST) begin
                hold_d[i] = hold_q[i];
            end else begin
                hold_d[i] = hold_q[i] + HOLD_ONE;
            end
            long_d[i] = level_q[i] && (hold_q[i] == HOLD_FIRE);
        end
    end

    // LED counter reacts to the registered pulses; long press on channel 0 has top priority.
    always_comb begin
        led_d = led_q;
        if (long_q[0]) begin
            led_d = LED_ZERO;
        end else if (press_q[0] && dec_s) begin
            led_d = led_q;
        end else if (press_q[0]) begin
            led_d = led_q + LED_ONE;
        end else if (dec_s) begin
            led_d = led_q - LED_ONE;
        end else begin
            led_d = led_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= RAW_IDLE;
            sync2_q   <= RAW_IDLE;
            stable_q  <= BTN_ZERO;
            level_q   <= BTN_ZERO;
            press_q   <= BTN_ZERO;
            release_q <= BTN_ZERO;
            long_q    <= BTN_ZERO;
            led_q     <= LED_ZERO;
            for (int i = 0; i < NUM_BTN; i++) begin
                db_cnt_q[i] <= DB_ZERO;
                hold_q[i]   <= HOLD_ZERO;
            end
        end else begin
            sync1_q   <= btn;
            sync2_q   <= sync1_q;
            stable_q  <= stable_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            led_q     <= led_d;
            for (int i = 0; i < NUM_BTN; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
                hold_q[i]   <= hold_d[i];
            end
        end
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;
    assign btn_long    = long_q;
    assign led         = led_q;

endmodule

// File: tb/tb_button_ctrl.sv
// Bench for button_ctrl: window-based behavioural model checked every cycle, plus directed
// scenarios with hand-computed edge numbers and LED values.
module tb_button_ctrl;

    localparam int D  = 8;
    localparam int L  = 32;
    localparam int NB = 2;
    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NB-1:0] btn = 2'b11;
    logic [NB-1:0] btn_level, btn_press, btn_release, btn_long;
    logic [LW-1:0] led;

    button_ctrl #(
        .NUM_BTN(NB), .LED_WIDTH(LW), .DEBOUNCE_CYCLES(D),
        .LONG_PRESS_CYCLES(L), .BTN_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .btn(btn),
        .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
        .btn_long(btn_long), .led(led)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: actual=%0d expected=%0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model: a level flips once the D samples taken 2..D+1 edges ago all disagree with it.
    bit            samp [NB][D+2];
    bit            mstable [NB];
    logic [NB-1:0] e_level, e_press, e_release, e_long;
    logic [NB-1:0] lev_prev, p_prev, l_prev;
    logic [LW-1:0] e_led;
    int            cyc;
    int            press_at [NB];
    bit            all_diff;

    always begin
        @(posedge clk);
        #1;
        if (rst) begin
            for (int c = 0; c < NB; c++) begin
                for (int k = 0; k < D + 2; k++) samp[c][k] = 1'b0;
                mstable[c]  = 1'b0;
                press_at[c] = -1000;
            end
            e_level = 2'b00; e_press = 2'b00; e_release = 2'b00; e_long = 2'b00;
            e_led = 4'h0; cyc = 0;
        end else begin
            lev_prev = e_level; p_prev = e_press; l_prev = e_long;
            cyc++;
            for (int c = 0; c < NB; c++) begin
                for (int k = D + 1; k > 0; k--) samp[c][k] = samp[c][k-1];
                samp[c][0] = ~btn[c];
                e_level[c] = mstable[c];
            end
            e_press   = e_level & ~lev_prev;
            e_release = ~e_level & lev_prev;
            for (int c = 0; c < NB; c++) begin
                e_long[c] = lev_prev[c] && (cyc - press_at[c] == L - 1);
                if (e_press[c]) press_at[c] = cyc;
            end
            if (l_prev[0])             e_led = 4'h0;
            else if (p_prev == 2'b11)  e_led = e_led;
            else if (p_prev[0])        e_led = e_led + 4'h1;
            else if (p_prev[1])        e_led = e_led - 4'h1;
            for (int c = 0; c < NB; c++) begin
                all_diff = 1'b1;
                for (int k = 2; k <= D + 1; k++)
                    if (samp[c][k] == mstable[c]) all_diff = 1'b0;
                if (all_diff) mstable[c] = ~mstable[c];
            end
        end
        chk("model_level",   btn_level,   e_level);
        chk("model_press",   btn_press,   e_press);
        chk("model_release", btn_release, e_release);
        chk("model_long",    btn_long,    e_long);
        chk("model_led",     led,         e_led);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [NB-1:0] v);
        @(negedge clk);
        btn = v;
    endtask

    task automatic hold(input logic [NB-1:0] v, input int n);
        drive(v);
        repeat (n) step();
    endtask

    int nlong;

    initial begin
        repeat (3) step();
        chk("reset_led", led, 0);
        chk("reset_level", btn_level, 0);
        chk("reset_press", btn_press, 0);
        @(negedge clk) rst = 1'b0;
        repeat (4) step();

        // First press: level and pulse at edge 10, LED one edge later
        drive(2'b10);
        for (int e = 0; e < 12; e++) begin
            step();
            if (e == 9) chk("press_early_level", btn_level[0], 0);
            if (e == 10) begin
                chk("press_level", btn_level[0], 1);
                chk("press_pulse", btn_press[0], 1);
                chk("press_led_before", led, 0);
            end
            if (e == 11) begin
                chk("press_width", btn_press[0], 0);
                chk("press_led", led, 1);
            end
        end
        hold(2'b11, 12);

        // Glitch shorter than the debounce window
        hold(2'b10, 5);
        hold(2'b11, 12);
        chk("glitch_level", btn_level, 0);
        chk("glitch_led", led, 1);

        // Wrap: reset, 16 increments back to 0, then one decrement to 4'hF
        @(negedge clk) rst = 1'b1;
        step();
        chk("rst_led", led, 0);
        @(negedge clk) rst = 1'b0;
        for (int n = 0; n < 16; n++) begin
            hold(2'b10, 12);
            hold(2'b11, 12);
        end
        chk("wrap_up_led", led, 0);
        hold(2'b01, 12);
        hold(2'b11, 12);
        chk("wrap_down_led", led, 15);

        // Simultaneous press and release
        drive(2'b00);
        for (int e = 0; e < 12; e++) begin
            step();
            if (e == 10) chk("simul_press", btn_press, 3);
        end
        chk("simul_led", led, 15);
        drive(2'b11);
        for (int e = 0; e < 12; e++) begin
            step();
            if (e == 10) chk("simul_release", btn_release, 3);
        end

        // Bring LED to 5 (15 + 6 mod 16)
        for (int n = 0; n < 6; n++) begin
            hold(2'b10, 12);
            hold(2'b11, 12);
        end
        chk("prelong_led", led, 5);

        // Long press: press at edge 10, long at 41, LED cleared at 42, no repeat
        nlong = 0;
        drive(2'b10);
        for (int e = 0; e < 56; e++) begin
            step();
            if (btn_long[0]) nlong++;
            if (e == 10) chk("long_press_pulse", btn_press[0], 1);
            if (e == 11) chk("long_led_inc", led, 6);
            if (e == 40) chk("long_early", btn_long[0], 0);
            if (e == 41) chk("long_pulse", btn_long[0], 1);
            if (e == 42) chk("long_led_clear", led, 0);
        end
        chk("long_once", nlong, 1);
        hold(2'b11, 12);

        // Reset while btn[1] held mid-debounce; re-accepted 10 edges after release of reset
        drive(2'b01);
        repeat (6) step();
        @(negedge clk) rst = 1'b1;
        step();
        chk("midrst_level", btn_level, 0);
        chk("midrst_press", btn_press, 0);
        chk("midrst_led", led, 0);
        @(negedge clk) rst = 1'b0;
        for (int e = 0; e < 12; e++) begin
            step();
            if (e == 9) chk("midrst_early", btn_level[1], 0);
            if (e == 10) chk("midrst_press_after", btn_press[1], 1);
            if (e == 11) chk("midrst_led_dec", led, 15);
        end
        hold(2'b11, 12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/button_ctrl.md
Name: button_ctrl

Overview:
Parametrised multi-button front end and LED counter. It is the next generation of the two-button LED demo block. It takes NUM_BTN raw push-button inputs and for each one does the following: synchronises it, debounces it, and produces level, press, release and long-press outputs. Press events drive a wrapping LED_WIDTH-bit up/down counter that is shown on the PMOD LEDs. It sits directly under the board top level, on the 100 MHz clock.

Parameters:
NUM_BTN, 2, number of button channels (1..8)
LED_WIDTH, 4, width of LED counter/output
DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a level change (10 ms at 100 MHz); minimum 2
LONG_PRESS_CYCLES, 100000000, cycles a debounced press must be held before the long-press event fires (1 s); must exceed DEBOUNCE_CYCLES
BTN_ACTIVE_LOW, 1, 1 = raw input reads 0 when pressed

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active high
btn  input  NUM_BTN  raw asynchronous button inputs
btn_level  output  NUM_BTN  debounced level, 1 = pressed
btn_press  output  NUM_BTN  one-cycle pulse on accepted press
btn_release  output  NUM_BTN  one-cycle pulse on accepted release
btn_long  output  NUM_BTN  one-cycle pulse when hold reaches LONG_PRESS_CYCLES
led  output  LED_WIDTH  LED counter value

Behaviour:
- Interface (already decided): one clock, clk; reset rst is synchronous and active-high.
- Reset: btn_level, btn_press, btn_release, btn_long and led are all 0. Synchronisers, debounce counters and hold counters are cleared. The stable state is "released", whatever btn reads.
- Per channel, the raw input passes through a 2-flop synchroniser. It is then normalised so that 1 = pressed (inverted when BTN_ACTIVE_LOW=1).
- Debounce, per channel:
  - Counter width is $clog2(DEBOUNCE_CYCLES).
  - While the synchronised value equals btn_level, the counter is held at 0.
  - While it differs, the counter increments each cycle.
  - When the counter reaches DEBOUNCE_CYCLES-1 and the value still differs, btn_level toggles and the counter clears.
  - Any return to equality before that point clears the counter, so no event is produced.
- Latency: the raw change is first sampled at edge 0. btn_level changes, and the press/release pulse asserts, at edge 2+DEBOUNCE_CYCLES. Each pulse lasts exactly 1 cycle.
- btn_press[i] is 1 in the same cycle that btn_level[i] rises. btn_release[i] is 1 in the same cycle that btn_level[i] falls.
- Long press, per channel:
  - The hold counter increments every cycle while btn_level=1 and clears when btn_level=0.
  - btn_long asserts for 1 cycle when the counter reaches LONG_PRESS_CYCLES-1, counted from the btn_press cycle.
  - The counter then saturates, so there is no repeat until a release.
- LED counter, updated on the cycle after the pulses (registered), with the following priority:
  1. btn_long[0]: led <= 0.
  2. btn_press[0] and btn_press[1] in the same cycle: no change.
  3. btn_press[0] alone: led <= led+1, wrapping from all-ones to 0.
  4. btn_press[1] alone (only if NUM_BTN>=2): led <= led-1, wrapping from 0 to all-ones.
  - Channels 2 and above do not affect led; they only drive their event outputs.
- rst asserted mid-debounce or mid-hold: all state clears on that edge and no pulses are emitted in that cycle.
- Button held through reset release: it is accepted as a new press at 2+DEBOUNCE_CYCLES edges after reset deasserts.

Test Plan (DEBOUNCE_CYCLES=8, LONG_PRESS_CYCLES=32, NUM_BTN=2, LED_WIDTH=4, BTN_ACTIVE_LOW=1):
- Reset with btn=2'b11 -> all outputs 0. btn[0] driven low at edge 0 -> btn_level[0] and btn_press[0] rise at edge 10, press is 1 cycle wide, led=1 one cycle later.
- Glitch: btn[0] low for 5 cycles then high -> no btn_level/btn_press change, led unchanged.
- Wrap: 16 debounced presses of btn[0] -> led ends at 0. One btn[1] press from led=0 -> led=4'hF.
- Simultaneous: btn[0] and btn[1] pressed on the same edge -> both press pulses in the same cycle, led unchanged. Releases -> two btn_release pulses.
- Long press: btn[0] held 40 cycles after acceptance from led=5 -> btn_press increments to 6, btn_long pulses once at 31 cycles after btn_press, led=0, no second btn_long before release.
- rst pulsed while btn[1] held and mid-debounce (counter=4) -> all outputs 0. After rst deasserts, btn_press[1] fires 10 edges later.
